// File: rtl/bsg_mul_booth_4_iter_if.sv
// bsg_mul_booth_4_iter_if
//   Bundles the operand handshake (valid/ready) and the product handshake
//   (valid/yumi) of the iterative Booth multiplier into one port.
//
//   Ports (signal names are from the multiplier's point of view):
//     v_i      operands valid            ready_o  multiplier can accept
//     a_i      multiplicand              b_i      multiplier
//     signed_i 1: two's complement, 0: unsigned
//     v_o      product valid             yumi_i   consumer takes product
//     z_o      2*width_p product
//
//   Modports: master = producer/consumer side, slave = multiplier side.
interface bsg_mul_booth_4_iter_if #(
  parameter int width_p = 32
);
  logic                   v_i;
  logic                   ready_o;
  logic [width_p-1:0]     a_i;
  logic [width_p-1:0]     b_i;
  logic                   signed_i;
  logic                   v_o;
  logic                   yumi_i;
  logic [2*width_p-1:0]   z_o;

  modport master (
    output v_i, a_i, b_i, signed_i, yumi_i,
    input  ready_o, v_o, z_o
  );

  modport slave (
    input  v_i, a_i, b_i, signed_i, yumi_i,
    output ready_o, v_o, z_o
  );
endinterface

// File: rtl/bsg_mul_booth_4_iter.sv
// bsg_mul_booth_4_iter
//   Iterative radix-4 Booth multiplier. One operation in flight at a time:
//   operands are accepted on v_i & ready_o, pp_per_cycle_p Booth digits are
//   accumulated per CALC cycle, and the product is held on z_o with v_o=1
//   until the consumer asserts yumi_i. A new operation may be accepted in the
//   same cycle the previous product is taken.
//
//   Ports:
//     clk_i      clock
//     reset_n_i  asynchronous active-low reset
//     bus        slave modport of bsg_mul_booth_4_iter_if (operand and
//                product handshakes, operands, product)
module bsg_mul_booth_4_iter #(
  parameter int width_p        = 32,
  parameter int pp_per_cycle_p = 1
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_mul_booth_4_iter_if.slave  bus
);

  localparam int D  = (width_p + 2) / 2;
  localparam int N  = (D + pp_per_cycle_p - 1) / pp_per_cycle_p;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * width_p;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_acc;
  logic [width_p:0]   r_a;
  logic [width_p+2:0] r_b;

  logic               w_ready;
  logic               w_accept;
  logic               w_ext_a;
  logic               w_ext_b;
  logic [PW-1:0]      w_sum;
  logic [PW-1:0]      w_mcand;
  logic [PW-1:0]      w_pp;
  logic [2:0]         w_grp;
  int                 w_j;

  // ready_o is combinational on yumi_i so a product can be retired and the
  // next operands taken in the same cycle; gating with reset_n_i keeps it
  // low while reset is held.
  assign w_ready  = reset_n_i & ((r_state == IDLE) | ((r_state == DONE) & bus.yumi_i));
  assign w_accept = bus.v_i & w_ready;
  assign w_ext_a  = bus.signed_i & bus.a_i[width_p-1];
  assign w_ext_b  = bus.signed_i & bus.b_i[width_p-1];

  assign bus.ready_o = w_ready;
  assign bus.v_o     = (r_state == DONE);
  assign bus.z_o     = r_acc;

  // Sum of this cycle's Booth partial products. The multiplicand is
  // sign-extended to the full product width so that every partial product,
  // including negated ones, is correct modulo 2^(2*width_p). Digits beyond
  // the last one (only possible in the final iteration) contribute nothing.
  always_comb begin
    w_sum   = '0;
    w_pp    = '0;
    w_grp   = '0;
    w_j     = 0;
    w_mcand = {{(width_p-1){r_a[width_p]}}, r_a};
    for (int k = 0; k < pp_per_cycle_p; k++) begin
      w_j = int'(r_cnt) * pp_per_cycle_p + k;
      if (w_j < D) begin
        w_grp = 3'(r_b >> (2 * w_j));
        case (w_grp)
          3'b001, 3'b010: w_pp = w_mcand;
          3'b011:         w_pp = w_mcand << 1;
          3'b100:         w_pp = PW'(0) - (w_mcand << 1);
          3'b101, 3'b110: w_pp = PW'(0) - w_mcand;
          default:        w_pp = '0;
        endcase
        w_sum = w_sum + (w_pp << (2 * w_j));
      end
    end
  end

  // Control FSM and datapath registers. Operands are captured with their
  // extension bits (and the Booth guard bit below b) at accept, so signed_i
  // only matters in that cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        CALC: begin
          r_acc <= r_acc + w_sum;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.yumi_i && !w_accept) begin
            r_state <= IDLE;
          end
        end
        default: ;
      endcase
      if (w_accept) begin
        r_a     <= {w_ext_a, bus.a_i};
        r_b     <= {w_ext_b, w_ext_b, bus.b_i, 1'b0};
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= CALC;
      end
    end
  end

endmodule

// File: tb/tb_bsg_mul_booth_4_iter.sv
// tb_bsg_mul_booth_4_iter
//   Directed bench for the iterative Booth multiplier. Three instances share
//   clock and reset: 32-bit with 4 digits per cycle (latency 6), 32-bit with
//   1 digit per cycle (latency 18), and 4-bit with all 3 digits in one cycle
//   (latency 2) which is swept over every operand pair in both modes.
module tb_bsg_mul_booth_4_iter;

  logic clk;
  logic reset_n;

  int tests_run;
  int tests_failed;

  bsg_mul_booth_4_iter_if #(.width_p(32)) if4 ();
  bsg_mul_booth_4_iter_if #(.width_p(32)) if1 ();
  bsg_mul_booth_4_iter_if #(.width_p(4))  ifw ();

  bsg_mul_booth_4_iter #(.width_p(32), .pp_per_cycle_p(4)) u_pp4 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(if4.slave)
  );

  bsg_mul_booth_4_iter #(.width_p(32), .pp_per_cycle_p(1)) u_pp1 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(if1.slave)
  );

  bsg_mul_booth_4_iter #(.width_p(4), .pp_per_cycle_p(3)) u_w4 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(ifw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on the pp=4 instance (assumed idle), count edges from
  // the accept edge until v_o, optionally retire the product.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic pop, output logic [63:0] z, output int lat);
    if4.a_i      = a;
    if4.b_i      = b;
    if4.signed_i = s;
    if4.v_i      = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      if4.v_i = 1'b0;
      lat++;
    end while (!if4.v_o && lat < 100);
    z = if4.z_o;
    if (pop) begin
      if4.yumi_i = 1'b1;
      @(posedge clk); #1;
      if4.yumi_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (if4.ready_o !== 1'b0 || if4.v_o !== 1'b0 || if4.z_o !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pp4 ready=%b v=%b z=%h required 0 0 0", if4.ready_o, if4.v_o, if4.z_o);
    end
    tests_run++;
    if (if1.ready_o !== 1'b0 || if1.v_o !== 1'b0 || if1.z_o !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pp1 ready=%b v=%b z=%h required 0 0 0", if1.ready_o, if1.v_o, if1.z_o);
    end
    tests_run++;
    if (ifw.ready_o !== 1'b0 || ifw.v_o !== 1'b0 || ifw.z_o !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_w4 ready=%b v=%b z=%h required 0 0 0", ifw.ready_o, ifw.v_o, ifw.z_o);
    end
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (if4.ready_o !== 1'b1 || if1.ready_o !== 1'b1 || ifw.ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_reset got %b%b%b required 111", if4.ready_o, if1.ready_o, ifw.ready_o);
    end
  endtask

  task automatic test_unsigned_max();
    int lat;
    logic [63:0] z;
    if1.a_i      = 32'hFFFF_FFFF;
    if1.b_i      = 32'hFFFF_FFFF;
    if1.signed_i = 1'b0;
    if1.v_i      = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      if1.v_i = 1'b0;
      lat++;
    end while (!if1.v_o && lat < 100);
    z = if1.z_o;
    tests_run++;
    if (z !== 64'hFFFF_FFFE_0000_0001 || lat != 18) begin
      tests_failed++;
      $display("[TB] FAIL unsigned_max z=%h lat=%0d required FFFFFFFE00000001 lat=18", z, lat);
    end
    if1.yumi_i = 1'b1;
    @(posedge clk); #1;
    if1.yumi_i = 1'b0;
    tests_run++;
    if (if1.v_o !== 1'b0 || if1.ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pp1_after_yumi v=%b ready=%b required v=0 ready=1", if1.v_o, if1.ready_o);
    end
  endtask

  task automatic test_corners();
    logic [31:0] ta [9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0003,
                            32'h0000_0000};
    logic [31:0] tb [9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF,
                            32'h0000_0005, 32'h0000_0002, 32'h8000_0000, 32'h0000_0005,
                            32'hFFFF_FFFF};
    logic        ts [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] te [9] = '{64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001,
                            64'hFFFF_FFFF_8000_0000, 64'h3FFF_FFFF_0000_0001,
                            64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0001_FFFF_FFFE,
                            64'h4000_0000_0000_0000, 64'h0000_0000_0000_000F,
                            64'h0000_0000_0000_0000};
    logic [63:0] z;
    int lat;
    for (int i = 0; i < 9; i++) begin
      run32(ta[i], tb[i], ts[i], 1'b1, z, lat);
      tests_run++;
      if (z !== te[i] || lat != 6) begin
        tests_failed++;
        $display("[TB] FAIL corner_%0d z=%h lat=%0d required %h lat=6", i, z, lat, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] z;
    int lat;
    run32(32'd7, 32'd9, 1'b0, 1'b0, z, lat);
    tests_run++;
    if (z !== 64'd63 || lat != 6) begin
      tests_failed++;
      $display("[TB] FAIL bp_first z=%h lat=%0d required 3f lat=6", z, lat);
    end
    if4.a_i      = 32'hFFFF_FFFF;
    if4.b_i      = 32'hFFFF_FFFF;
    if4.signed_i = 1'b1;
    if4.v_i      = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (if4.ready_o !== 1'b0 || if4.v_o !== 1'b1 || if4.z_o !== 64'd63) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d ready=%b v=%b z=%h required 0 1 3f", c, if4.ready_o, if4.v_o, if4.z_o);
      end
    end
    if4.yumi_i = 1'b1;
    #1;
    tests_run++;
    if (if4.ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_ready_on_yumi got %b required 1", if4.ready_o);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      if4.yumi_i = 1'b0;
      if4.v_i    = 1'b0;
      lat++;
    end while (!if4.v_o && lat < 100);
    tests_run++;
    if (if4.z_o !== 64'd1 || lat != 6) begin
      tests_failed++;
      $display("[TB] FAIL bp_second z=%h lat=%0d required 1 lat=6", if4.z_o, lat);
    end
    if4.yumi_i = 1'b1;
    @(posedge clk); #1;
    if4.yumi_i = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] z;
    int lat;
    if4.a_i      = 32'h1234_5678;
    if4.b_i      = 32'h5678_1234;
    if4.signed_i = 1'b0;
    if4.v_i      = 1'b1;
    @(posedge clk); #1;
    if4.v_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (if4.v_o !== 1'b0 || if4.ready_o !== 1'b0 || if4.z_o !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_calc_reset v=%b ready=%b z=%h required 0 0 0", if4.v_o, if4.ready_o, if4.z_o);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (if4.ready_o !== 1'b1 || if4.v_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset ready=%b v=%b required 1 0", if4.ready_o, if4.v_o);
    end
    run32(32'd3, 32'd5, 1'b0, 1'b1, z, lat);
    tests_run++;
    if (z !== 64'd15 || lat != 6) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_op z=%h lat=%0d required f lat=6", z, lat);
    end
  endtask

  task automatic test_width4_exhaustive();
    logic [3:0]        a, b;
    logic signed [7:0] sa, sb;
    logic [7:0]        exp, z;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          a  = 4'(ai);
          b  = 4'(bi);
          sa = (s == 1) ? {{4{a[3]}}, a} : {4'b0, a};
          sb = (s == 1) ? {{4{b[3]}}, b} : {4'b0, b};
          exp = 8'(sa * sb);
          ifw.a_i      = a;
          ifw.b_i      = b;
          ifw.signed_i = (s == 1);
          ifw.v_i      = 1'b1;
          lat = 0;
          do begin
            @(posedge clk); #1;
            ifw.v_i = 1'b0;
            lat++;
          end while (!ifw.v_o && lat < 100);
          z = ifw.z_o;
          tests_run++;
          if (z !== exp || lat != 2) begin
            tests_failed++;
            $display("[TB] FAIL w4_s%0d_%h_%h z=%h lat=%0d required %h lat=2", s, a, b, z, lat, exp);
          end
          ifw.yumi_i = 1'b1;
          @(posedge clk); #1;
          ifw.yumi_i = 1'b0;
        end
      end
    end
  endtask

  // Test sequence: reset first, then each scenario in turn.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b1;
    if4.v_i = 1'b0; if4.yumi_i = 1'b0; if4.a_i = '0; if4.b_i = '0; if4.signed_i = 1'b0;
    if1.v_i = 1'b0; if1.yumi_i = 1'b0; if1.a_i = '0; if1.b_i = '0; if1.signed_i = 1'b0;
    ifw.v_i = 1'b0; ifw.yumi_i = 1'b0; ifw.a_i = '0; ifw.b_i = '0; ifw.signed_i = 1'b0;
    test_reset();
    test_unsigned_max();
    test_corners();
    test_back_to_back();
    test_reset_mid_calc();
    test_width4_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_mul_booth_4_iter.md
# bsg_mul_booth_4_iter

Iterative radix-4 Booth multiplier, parameterised in operand width and in the number of Booth partial products retired per cycle. It handles signed and unsigned operands, selected per operation. It supersedes the fixed-size, purely combinational Booth block arrays for datapaths that trade latency for area. It sits behind a valid/ready producer and in front of a valid/yumi consumer, and holds one operation at a time.

## Interface
- width_p, 32, operand width; even, >= 4
- pp_per_cycle_p, 1, Booth digits accumulated per CALC cycle; 1 <= pp_per_cycle_p <= D, where D = (width_p+2)/2
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous, active-low
- v_i  in  1  operands valid
- ready_o  out  1  block can accept operands
- a_i  in  width_p  multiplicand
- b_i  in  width_p  multiplier
- signed_i  in  1  1: both operands two's complement; 0: both unsigned
- v_o  out  1  product valid
- yumi_i  in  1  consumer takes product; legal only when v_o=1
- z_o  out  2*width_p  product

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, counter=0, acc=0; asynchronous assertion takes effect immediately.
- Outputs:
  - ready_o = reset_n_i & ((state==IDLE) | (state==DONE & yumi_i)).
  - v_o = (state==DONE).
  - z_o = acc.
  - During reset: ready_o=0, v_o=0, z_o=0.
- Accept (v_i & ready_o):
  - Latch the multiplicand as A = {ext, a_i}, width_p+1 bits.
  - Latch the multiplier as B = {ext, ext, b_i, 1'b0}, width_p+3 bits; the low 0 is the Booth guard bit.
  - ext = signed_i ? MSB : 0.
  - acc <= 0, counter <= 0, state <= CALC.
- CALC cycle:
  - For k in 0..pp_per_cycle_p-1 with global digit j = counter*pp_per_cycle_p + k < D, recode bits B[2j+2:2j] into digit d_j in {-2,-1,0,1,2} using the standard radix-4 table.
  - acc <= acc + sum_k (d_j * A) << 2j, all arithmetic modulo 2^(2*width_p). Digits with j >= D contribute 0.
  - counter increments. After the last iteration (counter == N-1, N = ceil(D/pp_per_cycle_p)) state <= DONE.
- Width rule: the exact product fits in 2*width_p bits for both modes, so modular accumulation gives the exact result. No saturation and no overflow flag.
- DONE: hold acc and v_o until yumi_i.
  - yumi_i without v_i: state <= IDLE.
  - yumi_i with v_i: the new operands are accepted in the same cycle and state <= CALC directly (back-to-back).
- v_i while in CALC/DONE without yumi_i: ignored (ready_o=0). The producer holds its operands.
- signed_i is sampled only at accept.
- Reset mid-CALC or mid-DONE: the operation is discarded. No v_o is produced for it.

## Timing
- Accept in cycle 0; CALC in cycles 1..N; v_o=1 from cycle N+1 until the yumi_i cycle inclusive.
- Latency: N+1 cycles from accept to v_o.
  - width_p=32, pp=1: D=17, N=17, latency 18.
  - width_p=32, pp=4: N=5, latency 6.
  - pp=D: N=1, latency 2.
- Throughput with yumi_i asserted immediately: one product per N+1 cycles (overlap through the DONE-accept path).
- ready_o depends combinationally on yumi_i. No other combinational input-to-output path exists.
- z_o is stable throughout DONE and changes only on the cycle after a yumi_i.

## Test plan
- Unsigned max: width_p=32, pp=1, a=b=0xFFFF_FFFF, signed_i=0 -> v_o at cycle 18, z_o=0xFFFF_FFFE_0000_0001.
- Signed corners, pp=4:
  - 0x8000_0000 * 0x8000_0000 -> 0x4000_0000_0000_0000, v_o at cycle 6.
  - 0xFFFF_FFFF * 0xFFFF_FFFF -> 0x0000_0000_0000_0001.
  - 0x8000_0000 * 0x0000_0001 -> 0xFFFF_FFFF_8000_0000.
- Backpressure: hold yumi_i=0 for 10 cycles in DONE with v_i=1 -> ready_o=0, z_o constant, no accept. Then yumi_i=1 with new v_i -> same-cycle accept, next v_o N+1 cycles later.
- Reset mid-CALC: assert reset_n_i=0 at CALC cycle 3 -> v_o, ready_o, z_o drop to 0 immediately. After release, ready_o=1 and the next operation 3*5 yields 15 with no stale result.
- Parameter sweep: width_p in {4,8,16,32,64}, pp in {1,2,3,D}, 10k random operations with random signed_i and random yumi_i delay -> every z_o equals the golden 2*width_p product; latency equals N+1.
- Small exhaustive: width_p=4, all 256 operand pairs in both modes -> exact products, e.g. signed 0x8*0x8=0x40, unsigned 0xF*0xF=0xE1.
